// File: rtl/grad_cells_valve_seq.sv
// Settle/dwell/close sequencer that routes a binary-tree fluid MUX through every enabled outlet.
// Define GRADCELL_LOOP_EN to repeat sweeps until abort or reset instead of stopping after one.
module grad_cells_valve_seq #(
  parameter int N_CH    = 4,
  parameter int DWELL_W = 16,
  parameter int SETTLE  = 4,
  localparam int L      = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic [2*L-1:0]     ctrl,
  output logic [L-1:0]       ch_active,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int CW = (DWELL_W > SW) ? DWELL_W : SW;
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_OPEN, S_DWELL, S_CLOSE, S_ADV} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_CH-1:0]    mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [L-1:0]       ch_q, ch_d;
  logic [2*L-1:0]     ctrl_q, ctrl_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  logic [N_CH-1:0]    above;
  logic [2*L-1:0]     route;

  function automatic logic [L-1:0] lowest_set(input logic [N_CH-1:0] m);
    lowest_set = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = L'(i);
    end
  endfunction

  // Enabled channels strictly after the one being served.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_above
      assign above[gi] = mask_q[gi] && (L'(gi) > ch_q);
    end
    // The root level steers on the channel MSB; a 0 bit vents the left valve.
    for (gi = 0; gi < L; gi++) begin : g_route
      assign route[2*gi]   =  ch_d[L-1-gi];
      assign route[2*gi+1] = ~ch_d[L-1-gi];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    dwell_d   = dwell_q;
    ch_d      = ch_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = ch_mask;
          dwell_d = (dwell_cycles == '0) ? '0 : dwell_cycles - 1'b1;
          if (ch_mask != '0) begin
            state_d = S_OPEN;
            ch_d    = lowest_set(ch_mask);
            cnt_d   = SETTLE_M1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_OPEN: begin
        if (cnt_q == '0) begin
          state_d = S_DWELL;
          cnt_d   = CW'(dwell_q);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DWELL: begin
        if (cnt_q == '0) begin
          state_d = S_CLOSE;
          cnt_d   = SETTLE_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CLOSE: begin
        if (cnt_q == '0) state_d = S_ADV;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_ADV: begin
        if (above != '0) begin
          state_d = S_OPEN;
          ch_d    = lowest_set(above);
          cnt_d   = SETTLE_M1;
        end else begin
          done_d = 1'b1;
`ifdef GRADCELL_LOOP_EN
          state_d = S_OPEN;
          ch_d    = lowest_set(mask_q);
          cnt_d   = SETTLE_M1;
`else
          state_d = S_IDLE;
          ch_d    = '0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        ch_d    = '0;
      end
    endcase
    // Abort overrides whatever the sequencer decided this cycle.
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      ch_d      = '0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  always_comb begin
    busy_d = (state_d != S_IDLE);
    ctrl_d = '1;
    if (state_d == S_OPEN || state_d == S_DWELL) ctrl_d = route;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      dwell_q   <= '0;
      ch_q      <= '0;
      ctrl_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      dwell_q   <= dwell_d;
      ch_q      <= ch_d;
      ctrl_q    <= ctrl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign ctrl      = ctrl_q;
  assign ch_active = ch_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_grad_cells_valve_seq.sv
// Directed bench for grad_cells_valve_seq with N_CH=4, SETTLE=4; observes outputs on falling edges.
module tb_grad_cells_valve_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  ch_mask;
  logic [15:0] dwell_cycles;
  logic [3:0]  ctrl;
  logic [1:0]  ch_active;
  logic        busy;
  logic        done;
  logic        aborted;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-derived routes, root level on the channel MSB: ch0..ch3.
  logic [3:0] route_tab [0:3];

  grad_cells_valve_seq #(.N_CH(4), .DWELL_W(16), .SETTLE(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .ch_mask      (ch_mask),
    .dwell_cycles (dwell_cycles),
    .ctrl         (ctrl),
    .ch_active    (ch_active),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_levels();
    for (int l = 0; l < 2; l++) begin
      check_eq("one_valve_per_level", 32'({ctrl[2*l+1], ctrl[2*l]} != 2'b00), 32'd1);
    end
  endtask

  // Start a sweep at the current falling edge and check every cycle until done clears.
  task automatic run_sweep(input logic [3:0] mask, input logic [15:0] dwell, input bit disturb);
    int chs[$];
    int dw, cost, total, slot, off;
    logic [3:0] e_ctrl;
    logic [1:0] e_ch;
    logic       e_busy, e_done;
    for (int i = 0; i < 4; i++) if (mask[i]) chs.push_back(i);
    dw    = (dwell == 16'd0) ? 1 : int'(dwell);
    cost  = 8 + dw + 1;
    total = chs.size() * cost;
    ch_mask      = mask;
    dwell_cycles = dwell;
    start        = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= total + 1; c++) begin
      if (c <= total) begin
        slot   = (c - 1) / cost;
        off    = (c - 1) % cost;
        e_ch   = 2'(chs[slot]);
        e_busy = 1'b1;
        e_done = 1'b0;
        e_ctrl = (off < 4 + dw) ? route_tab[chs[slot]] : 4'hF;
      end else begin
        e_ch   = 2'd0;
        e_busy = 1'b0;
        e_done = 1'b1;
        e_ctrl = 4'hF;
      end
      check_eq("sweep_ctrl", 32'(ctrl), 32'(e_ctrl));
      check_eq("sweep_ch_active", 32'(ch_active), 32'(e_ch));
      check_eq("sweep_busy", 32'(busy), 32'(e_busy));
      check_eq("sweep_done", 32'(done), 32'(e_done));
      check_eq("sweep_aborted", 32'(aborted), 32'd0);
      check_levels();
      if (disturb && c == 7)  start = 1'b1;
      if (disturb && c == 8)  start = 1'b0;
      if (disturb && c == 20) begin
        ch_mask      = 4'b0000;
        dwell_cycles = 16'd3;
      end
      step();
    end
    check_eq("sweep_done_clears", 32'(done), 32'd0);
    check_eq("sweep_idle_busy", 32'(busy), 32'd0);
    $display("sweep mask=%b dwell=%0d disturb=%0d cycles=%0d", mask, dwell, disturb, total);
  endtask

  initial begin
    route_tab[0] = 4'b1010;
    route_tab[1] = 4'b0110;
    route_tab[2] = 4'b1001;
    route_tab[3] = 4'b0101;
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    ch_mask      = 4'b0000;
    dwell_cycles = 16'd0;
    repeat (3) step();
    check_eq("rst_ctrl", 32'(ctrl), 32'hF);
    check_eq("rst_ch_active", 32'(ch_active), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_aborted", 32'(aborted), 32'd0);
    rst = 1'b0;
    step();

`ifdef GRADCELL_LOOP_EN
    // Single channel ch3, dwell 2: 11-cycle period, done at 12, 23, 34...
    ch_mask      = 4'b1000;
    dwell_cycles = 16'd2;
    start        = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      check_eq("loop_busy", 32'(busy), 32'd1);
      check_eq("loop_done", 32'(done), 32'((c >= 12) && ((c - 12) % 11 == 0)));
      check_eq("loop_ctrl", 32'(ctrl), 32'((((c - 1) % 11) < 6) ? 4'b0101 : 4'hF));
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("loop_abort_pulse", 32'(aborted), 32'd1);
    check_eq("loop_abort_busy", 32'(busy), 32'd0);
    check_eq("loop_abort_ctrl", 32'(ctrl), 32'hF);
    check_eq("loop_abort_done", 32'(done), 32'd0);
    $display("loop mask=1000 dwell=2 aborted after 40 cycles");
`else
    run_sweep(4'b1111, 16'd10, 1'b0);
    step();
    run_sweep(4'b0101, 16'd0, 1'b0);
    step();

    // Empty mask: done only, no valve activity.
    ch_mask = 4'b0000;
    dwell_cycles = 16'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("empty_done", 32'(done), 32'd1);
    check_eq("empty_busy", 32'(busy), 32'd0);
    check_eq("empty_ctrl", 32'(ctrl), 32'hF);
    step();
    check_eq("empty_done_clears", 32'(done), 32'd0);
    check_eq("empty_ctrl_after", 32'(ctrl), 32'hF);
    $display("sweep mask=0000 done only");

    // Abort during ch1 dwell (cycles 24..33 of a full sweep).
    ch_mask = 4'b1111;
    dwell_cycles = 16'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 26; c++) step();
    check_eq("pre_abort_ch", 32'(ch_active), 32'd1);
    check_eq("pre_abort_ctrl", 32'(ctrl), 32'b0110);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_ctrl", 32'(ctrl), 32'hF);
    check_eq("abort_pulse", 32'(aborted), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_ch_active", 32'(ch_active), 32'd0);
    step();
    check_eq("abort_pulse_clears", 32'(aborted), 32'd0);
    check_eq("abort_no_late_done", 32'(done), 32'd0);
    $display("abort in ch1 dwell");
    run_sweep(4'b0011, 16'd2, 1'b0);
    step();

    // Mid-sweep start pulse and mask/dwell change must not alter the sweep.
    run_sweep(4'b1111, 16'd10, 1'b1);
    step();

    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("idle_abort_pulse", 32'(aborted), 32'd0);
    check_eq("idle_abort_busy", 32'(busy), 32'd0);
    $display("abort while idle");

    ch_mask = 4'b0100;
    dwell_cycles = 16'd3;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_wins_busy", 32'(busy), 32'd1);
    check_eq("start_wins_aborted", 32'(aborted), 32'd0);
    check_eq("start_wins_ctrl", 32'(ctrl), 32'b1001);
    check_eq("start_wins_ch", 32'(ch_active), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("start_wins_abort", 32'(aborted), 32'd1);
    step();
    $display("abort with start in idle");

    ch_mask = 4'b1111;
    dwell_cycles = 16'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ctrl", 32'(ctrl), 32'hF);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_aborted", 32'(aborted), 32'd0);
    check_eq("midrst_ch_active", 32'(ch_active), 32'd0);
    step();
    check_eq("midrst_after_done", 32'(done), 32'd0);
    check_eq("midrst_after_aborted", 32'(aborted), 32'd0);
    $display("reset mid-sweep");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
